// File: rtl/snow64_main_mem_multiport.sv
// Snow64 shared main memory: round-robin arbitrated line RAM with tagged responses.
// Define SNOW64_MAIN_MEM_WORD_MASK_EN to enable per-32-bit-word write masking.
module snow64_main_mem_multiport #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CHANNELS-1:0]                  in_req_valid,
  input  logic [NUM_CHANNELS-1:0]                  in_req_wr,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]       in_req_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]       in_req_data,
  input  logic [NUM_CHANNELS*(DATA_WIDTH/32)-1:0]  in_req_word_mask,
  output logic [NUM_CHANNELS-1:0]                  out_req_ready,
  output logic [NUM_CHANNELS-1:0]                  out_rsp_valid,
  output logic [DATA_WIDTH-1:0]                    out_rsp_data,
  output logic                                     out_busy
);

  localparam int NW    = DATA_WIDTH / 32;
  localparam int IW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [IW-1:0]         id;
    logic                  wr;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  rsp_t                    pipe [READ_LATENCY];

  logic [IW-1:0]           ptr;
  logic [IW-1:0]           gnt_id;
  logic [NUM_CHANNELS-1:0] gnt;
  logic                    acc;
  logic [IW:0]             sum;
  logic [IW-1:0]           idx;

  logic                    sel_wr;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [NW-1:0]           sel_mask;

  // first valid channel at or after ptr, wrapping
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    acc    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_CHANNELS))
        sum = sum - (IW+1)'(NUM_CHANNELS);
      idx = sum[IW-1:0];
      if (!acc && in_req_valid[idx]) begin
        acc      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
    if (rst) begin
      gnt = '0;
      acc = 1'b0;
    end
  end

  assign out_req_ready = gnt;

  always_comb begin
    sel_wr   = in_req_wr[gnt_id];
    sel_addr = in_req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data = in_req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    sel_mask = in_req_word_mask[gnt_id*NW +: NW];
  end

`ifdef SNOW64_MAIN_MEM_WORD_MASK_EN
  always_ff @(posedge clk) begin
    if (acc && sel_wr) begin
      for (int w = 0; w < NW; w++) begin
        if (sel_mask[w])
          mem[sel_addr][w*32 +: 32] <= sel_data[w*32 +: 32];
      end
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^sel_mask;

  always_ff @(posedge clk) begin
    if (acc && sel_wr)
      mem[sel_addr] <= sel_data;
  end
`endif

  // stage 0 captures the pre-write line, so reads see older writes only
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      if (acc)
        ptr <= (gnt_id == IW'(NUM_CHANNELS-1)) ? '0 : gnt_id + 1'b1;
      pipe[0].valid <= acc;
      pipe[0].id    <= gnt_id;
      pipe[0].wr    <= sel_wr;
      pipe[0].data  <= (acc && !sel_wr) ? mem[sel_addr] : '0;
      for (int i = 1; i < READ_LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    out_rsp_valid = '0;
    out_rsp_data  = '0;
    if (pipe[READ_LATENCY-1].valid) begin
      out_rsp_valid[pipe[READ_LATENCY-1].id] = 1'b1;
      if (!pipe[READ_LATENCY-1].wr)
        out_rsp_data = pipe[READ_LATENCY-1].data;
    end
  end

  always_comb begin
    out_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++)
      out_busy = out_busy | pipe[i].valid;
  end

endmodule
